// File: rtl/pipelined_adder.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : pipelined_adder                                            |
// | Description : Skewed, chunked add/subtract pipeline with valid/ready     |
// |               handshakes on both sides. One ripple chunk of             |
// |               CHUNK_WIDTH bits is summed per register stage; the lower  |
// |               result chunks and the still-unsummed upper operand chunks |
// |               travel with each item.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//
// Ports
//   clk_i        in   1      clock, all state on rising edge
//   rst_i        in   1      asynchronous, active-high reset
//   in_valid_i   in   1      operands/op valid
//   in_ready_o   out  1      operands accepted this cycle (combinational on
//                            out_ready_i)
//   in1_i        in   WIDTH  operand A
//   in2_i        in   WIDTH  operand B
//   carry_i      in   1      carry-in for add; ignored when sub_i=1
//   sub_i        in   1      0: A+B+carry_i   1: A-B
//   out_valid_o  out  1      result valid
//   out_ready_i  in   1      consumer accepts result
//   sum_o        out  WIDTH  result, modulo 2^WIDTH
//   carry_o      out  1      carry-out of MSB (sub: 1 = no borrow)
//   overflow_o   out  1      signed overflow
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_adder #(
   parameter int WIDTH       = 8,
   parameter int CHUNK_WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in1_i,
   input  logic [WIDTH-1:0] in2_i,
   input  logic             carry_i,
   input  logic             sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             overflow_o
);

   // Guarded so an illegal CHUNK_WIDTH cannot cause a divide-by-zero before
   // the elaboration check below reports it.
   localparam int c_stages = (CHUNK_WIDTH < 1) ? 1 : (WIDTH / CHUNK_WIDTH);
   localparam int c_last   = c_stages - 1;

   if (CHUNK_WIDTH < 1) begin : g_bad_chunk
      $error("pipelined_adder: CHUNK_WIDTH must be at least 1");
   end else if ((WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_width
      $error("pipelined_adder: WIDTH must be a multiple of CHUNK_WIDTH");
   end

   // Subtraction is A + ~B + 1, so the operand inversion and forced carry-in
   // happen once at the entry and every stage is a plain adder.
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin0;

   assign w_b_eff = sub_i ? ~in2_i : in2_i;
   assign w_cin0  = sub_i | carry_i;

   for (genvar k = 0; k < c_stages; k++) begin : g_stage
      localparam int c_lo = k * CHUNK_WIDTH;
      localparam int c_hi = c_lo + CHUNK_WIDTH - 1;

      logic [WIDTH-1:c_lo]    w_a_in;    // operand A bits not yet summed
      logic [WIDTH-1:c_lo]    w_b_in;    // operand B' bits not yet summed
      logic                   w_cin;     // carry into this chunk
      logic                   w_v_in;    // upstream valid
      logic [c_hi:0]          w_sum_in;  // result bits complete after this stage
      logic [CHUNK_WIDTH:0]   w_chunk;   // chunk sum with carry-out on top
      logic                   w_ld;      // stage may load this cycle
      logic                   w_ld_next; // downstream accepts this stage's item
      logic                   w_take;    // a real item is loaded

      logic                   r_v;
      logic [c_hi:0]          r_sum;
      logic                   r_c;

      if (k == 0) begin : g_src_in
         assign w_a_in   = in1_i;
         assign w_b_in   = w_b_eff;
         assign w_cin    = w_cin0;
         assign w_v_in   = in_valid_i;
         assign w_sum_in = w_chunk[CHUNK_WIDTH-1:0];
      end else begin : g_src_prev
         assign w_a_in   = g_stage[k-1].g_fwd.r_a;
         assign w_b_in   = g_stage[k-1].g_fwd.r_b;
         assign w_cin    = g_stage[k-1].r_c;
         assign w_v_in   = g_stage[k-1].r_v;
         assign w_sum_in = {w_chunk[CHUNK_WIDTH-1:0], g_stage[k-1].r_sum};
      end

      assign w_chunk = {1'b0, w_a_in[c_hi:c_lo]}
                     + {1'b0, w_b_in[c_hi:c_lo]}
                     + {{CHUNK_WIDTH{1'b0}}, w_cin};

      // A stage loads when empty or when its occupant moves on this cycle,
      // which lets bubbles collapse and sustains one item per cycle.
      assign w_ld   = !r_v || w_ld_next;
      assign w_take = w_ld && w_v_in;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_v <= 1'b0;
         end else if (w_ld) begin
            r_v <= w_v_in;
         end
      end

      // Data only moves with a real item so a stalled or drained output
      // keeps its last value.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_sum <= '0;
            r_c   <= 1'b0;
         end else if (w_take) begin
            r_sum <= w_sum_in;
            r_c   <= w_chunk[CHUNK_WIDTH];
         end
      end

      if (k == c_last) begin : g_last
         logic r_ovf;

         assign w_ld_next = out_ready_i;

         // Signed overflow: like-signed operands producing a differently
         // signed result. The MSB chunk is summed here, so all three signs
         // are visible in this stage.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_ovf <= 1'b0;
            end else if (w_take) begin
               r_ovf <= (w_a_in[WIDTH-1] == w_b_in[WIDTH-1]) &&
                        (w_chunk[CHUNK_WIDTH-1] != w_a_in[WIDTH-1]);
            end
         end
      end else begin : g_fwd
         logic [WIDTH-1:c_hi+1] r_a;
         logic [WIDTH-1:c_hi+1] r_b;

         assign w_ld_next = g_stage[k+1].w_ld;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_take) begin
               r_a <= w_a_in[WIDTH-1:c_hi+1];
               r_b <= w_b_in[WIDTH-1:c_hi+1];
            end
         end
      end
   end

   assign in_ready_o  = g_stage[0].w_ld;
   assign out_valid_o = g_stage[c_last].r_v;
   assign sum_o       = g_stage[c_last].r_sum;
   assign carry_o     = g_stage[c_last].r_c;
   assign overflow_o  = g_stage[c_last].g_last.r_ovf;

endmodule

`default_nettype wire
